ins_cache: RTL and testbench
============================

INS_CACHE -- requirements
Module: ins_cache

Interface
REQ-001 Parameter IDX_W, default 4: log2 of line count (16 lines).
REQ-002 Parameter OFS_W, default 2: log2 of words per line (4 words, 16 bytes).
REQ-003 clk  input  1  system clock, all state updates on posedge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 rdy  input  1  global ready; state frozen when low.
REQ-006 addr  input  32  fetch PC from instruction fetch stage.
REQ-007 hit  output  1  combinational; addr's line present and valid.
REQ-008 ins  output  32  combinational; cached word at addr, meaningful only when hit=1.
REQ-009 mem_req  output  1  word read request to memory controller.
REQ-010 mem_addr  output  32  word-aligned byte address of requested word.
REQ-011 mem_done  input  1  one-cycle pulse, mem_data valid for current request.
REQ-012 mem_data  input  32  fetched word, little-endian.
REQ-013 hit_cnt  output  32  hit counter (see Configuration).
REQ-014 miss_cnt  output  32  miss counter (see Configuration).

Function
REQ-015 Address split: word offset addr[OFS_W+1:2], index addr[OFS_W+IDX_W+1:OFS_W+2], tag remaining upper bits; addr[1:0] ignored.
REQ-016 Storage: per line a valid bit, tag, 2^OFS_W data words.
REQ-017 hit SHALL be 1 iff state is IDLE, valid[index]=1 and tag[index] equals addr tag; ins = data[index][offset] in the same cycle (zero latency).
REQ-018 FSM states: IDLE, FILL.
REQ-019 IDLE and rdy and not hit: latch line base (addr with offset and [1:0] cleared), clear word counter, go FILL next cycle; miss_cnt increments once.
REQ-020 FILL: mem_req=1, mem_addr = line base + 4*counter; mem_req held high until mem_done.
REQ-021 On mem_done in FILL: store mem_data into the fill word slot, counter+1; mem_req stays high for next word (new mem_addr next cycle).
REQ-022 On mem_done for last word (counter = 2^OFS_W-1): write tag, set valid, mem_req=0, return IDLE; hit for that line visible the following cycle.
REQ-023 valid SHALL stay 0 for the filling line until all words are written; partially filled lines never hit.
REQ-024 A fill, once started, SHALL complete even if addr changes (e.g. branch redirect); the new addr is evaluated on return to IDLE.
REQ-025 Replacement is direct-mapped; a fill overwrites the indexed line unconditionally.
REQ-026 mem_done outside FILL SHALL be ignored.
REQ-027 rdy=0: FSM, counter, arrays and counters hold; mem_req and mem_addr hold their values.
REQ-028 hit_cnt increments by 1 each rdy cycle with hit=1; both counters wrap modulo 2^32.

Reset
REQ-029 On rst: all valid bits 0, state IDLE, counter 0, mem_req 0, mem_addr 0, hit_cnt 0, miss_cnt 0; tags and data need not be cleared.
REQ-030 rst during FILL aborts the fill; the partial line remains invalid.
REQ-031 rst has priority over rdy.

Configuration
REQ-032 Macro ICACHE_STAT_EN: defined -> hit_cnt/miss_cnt counters implemented per REQ-019/REQ-028.
REQ-033 Macro undefined -> counter registers absent, hit_cnt and miss_cnt tied to 0; all other behaviour identical.

Verification
REQ-034 Reset, addr=0x0 -> hit=0 same cycle; next cycle mem_req=1, mem_addr=0x0; 4 mem_done pulses -> mem_addr 0x0,0x4,0x8,0xC; cycle after 4th, hit=1.
REQ-035 After fill of 0x0..0xC with 0x11,0x22,0x33,0x44: addr=0x8 -> hit=1, ins=0x33 same cycle, no mem_req.
REQ-036 Conflict: line 0x0 valid, addr=0x100 (same index, different tag) -> miss, fill 0x100..0x10C; then addr=0x0 -> miss again.
REQ-037 During fill of 0x40, addr changes to 0x200 after 2nd mem_done -> fill of 0x40 completes; then fill of 0x200 begins; hit on 0x40 afterwards.
REQ-038 rdy=0 for 5 cycles mid-fill with mem_done held 0 -> state/mem_addr unchanged; rst mid-fill -> mem_req=0, line invalid, next miss refetches from word 0.
REQ-039 With ICACHE_STAT_EN: 1 miss then 3 hit cycles -> miss_cnt=1, hit_cnt=3; without it both read 0.

Source files
------------

// File: rtl/ins_cache.sv
// ins_cache: direct-mapped instruction cache with word-serial line fill.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STAT_EN.
module ins_cache #(
  parameter int IDX_W = 4,
  parameter int OFS_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] addr,
  output logic        hit,
  output logic [31:0] ins,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << OFS_W;
  localparam int TAG_W = 30 - IDX_W - OFS_W;
  localparam int BASE_W = 30 - OFS_W;
  typedef enum logic {IDLE, FILL} state_t;
  state_t             state_q, state_d;
  logic [OFS_W-1:0]   cnt_q, cnt_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [31:0]        data_q [LINES][WORDS];
  logic [OFS_W-1:0]   ofs;
  logic [IDX_W-1:0]   idx, fidx;
  logic [TAG_W-1:0]   tag;
  logic               miss, wr, last;
  assign ofs  = addr[OFS_W+1:2];
  assign idx  = addr[OFS_W+IDX_W+1:OFS_W+2];
  assign tag  = addr[31:OFS_W+IDX_W+2];
  assign fidx = base_q[IDX_W-1:0];
  assign last = cnt_q == OFS_W'(WORDS - 1);
  assign hit  = state_q == IDLE && valid_q[idx] && tag_q[idx] == tag;
  assign ins  = data_q[idx][ofs];
  assign miss = rdy && state_q == IDLE && !hit;
  assign wr   = rdy && state_q == FILL && mem_done;
  assign mem_req  = state_q == FILL;
  assign mem_addr = {base_q, cnt_q, 2'b00};
  always_comb begin
    state_d = miss ? FILL : (wr && last) ? IDLE : state_q;
    cnt_d   = miss ? '0 : wr ? cnt_q + 1'b1 : cnt_q;
    base_d  = miss ? addr[31:OFS_W+2] : base_q;
  end
  // The indexed line is invalidated when a fill starts so an aborted fill can never hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      if (miss) valid_q[idx] <= 1'b0;
      if (wr && last) valid_q[fidx] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      data_q[fidx][cnt_q] <= mem_data;
      if (last) tag_q[fidx] <= base_q[BASE_W-1:IDX_W];
    end
  end
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      hit_cnt_q  <= hit_cnt_q + {31'b0, hit};
      miss_cnt_q <= miss_cnt_q + {31'b0, miss};
    end
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_ins_cache.sv
// tb_ins_cache: randomized scoreboard bench for ins_cache against a line-level cache model.
module tb_ins_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b1, rdy = 1'b1, mem_done = 1'b0;
  logic [31:0] addr = '0, mem_data = '0;
  logic        hit, mem_req;
  logic [31:0] ins, mem_addr, hit_cnt, miss_cnt;

  ins_cache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .addr(addr), .hit(hit), .ins(ins),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] ins;
    logic        req;
    logic        chk_addr;
    logic [31:0] maddr;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;

  // Reference model: 16 lines x 4 words, fill tracked as "which line, how many words so far".
  logic        mvalid [16];
  logic [25:0] mtag   [16];
  logic [31:0] mdata  [16][4];
  logic        busy = 1'b0, rst_addr = 1'b1;
  logic [31:0] fbase = '0;
  int          fcnt = 0;
  logic [31:0] hc = '0, mc = '0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    logic [31:0] w;
    w = {30'b0, a[3:2]} + 32'd1;
    return (a < 32'd16) ? 32'h11 * w : (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    busy = 1'b0; fcnt = 0; fbase = '0; hc = '0; mc = '0; rst_addr = 1'b1;
  endtask

  task automatic step(input logic r, input logic y, input logic [31:0] a, input logic d);
    exp_t e;
    int   i, fi;
    logic eh;
    @(negedge clk);
    rst = r; rdy = y; addr = a; mem_done = d;
    mem_data = busy ? memfn(fbase + 32'(4 * fcnt)) : $urandom;
    #1;
    i  = int'(a[5:4]) | (int'(a[7:6]) << 2);
    fi = int'(fbase[7:4]);
    eh = !busy && mvalid[i] && mtag[i] == a[31:6];
    e.hit = eh;
    e.ins = eh ? mdata[i][a[3:2]] : '0;
    e.req = busy;
    e.chk_addr = busy || rst_addr;
    e.maddr = busy ? fbase + 32'(4 * fcnt) : '0;
`ifdef ICACHE_STAT_EN
    e.hc = hc; e.mc = mc;
`else
    e.hc = '0; e.mc = '0;
`endif
    exp_q.push_back(e);
    if (r) model_reset();
    else if (y) begin
      if (eh) hc++;
      if (!busy && !eh) begin
        busy = 1'b1; fbase = {a[31:4], 4'b0}; fcnt = 0;
        mvalid[i] = 1'b0; mc++; rst_addr = 1'b0;
      end else if (busy && d) begin
        mdata[fi][fcnt] = mem_data;
        fcnt++;
        if (fcnt == 4) begin
          mvalid[fi] = 1'b1; mtag[fi] = fbase[31:6]; busy = 1'b0; fcnt = 0;
        end
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hit", {31'b0, hit}, {31'b0, e.hit});
        if (e.hit) chk("ins", ins, e.ins);
        chk("mem_req", {31'b0, mem_req}, {31'b0, e.req});
        if (e.chk_addr) chk("mem_addr", mem_addr, e.maddr);
        chk("hit_cnt", hit_cnt, e.hc);
        chk("miss_cnt", miss_cnt, e.mc);
      end
    end
  end

  initial begin
    logic [31:0] a;
    model_reset();
    repeat (2) @(negedge clk);
    step(0, 1, 32'h0, 0);
    repeat (2) step(0, 1, 32'h0, 0);
    repeat (4) step(0, 1, 32'h0, 1);
    step(0, 1, 32'h0, 0);
    step(0, 1, 32'h8, 0);
    step(0, 1, 32'h8, 0);
    step(0, 1, 32'h4, 0);
    step(0, 1, 32'h100, 0);
    repeat (4) step(0, 1, 32'h100, 1);
    step(0, 1, 32'h10C, 0);
    step(0, 1, 32'h0, 0);
    repeat (4) step(0, 1, 32'h0, 1);
    step(0, 1, 32'h40, 0);
    repeat (2) step(0, 1, 32'h40, 1);
    step(0, 1, 32'h200, 0);
    repeat (2) step(0, 1, 32'h200, 1);
    repeat (4) step(0, 1, 32'h200, 1);
    step(0, 1, 32'h44, 0);
    step(0, 1, 32'h80, 0);
    step(0, 1, 32'h80, 1);
    repeat (5) step(0, 0, 32'h80, 0);
    step(0, 0, 32'h84, 1);
    step(0, 1, 32'h80, 1);
    step(1, 1, 32'h80, 1);
    step(0, 1, 32'h80, 0);
    step(0, 1, 32'h80, 0);
    repeat (4) step(0, 1, 32'h80, 1);
    step(0, 1, 32'h88, 0);
    step(1, 1, 32'h0, 0);
    step(0, 1, 32'h0, 0);
    repeat (4) step(0, 1, 32'h0, 1);
    repeat (3) step(0, 1, 32'hC, 0);
    for (int n = 0; n < 4000; n++) begin
      a = {$urandom_range(0, 3) == 0 ? 24'h123456 : 24'h0, 2'($urandom_range(0, 3)), 6'($urandom)};
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, a,
           busy ? $urandom_range(0, 1) == 1 : $urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
